// File: rtl/cci_mpf_csr_event_ctrs.sv
// cci_mpf_csr_event_ctrs
//
// Event counter bank for the MPF CSR manager. Each event input drives a
// saturating counter with a sticky overflow flag. Counters are read through a
// fixed two-stage pipeline (no backpressure) and cleared individually or all
// at once. A clear wins over a same-cycle event on the same counter, and a read
// always observes the state from before the current edge's update.

module cci_mpf_csr_event_ctrs #(
  parameter int N_EVENTS  = 13,
  parameter int CTR_WIDTH = 48,
  parameter int IDX_W     = (N_EVENTS > 1) ? $clog2(N_EVENTS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [N_EVENTS-1:0] ev_in,
  input  logic                ev_enable,

  input  logic                clr_valid,
  input  logic                clr_all,
  input  logic [IDX_W-1:0]    clr_idx,

  input  logic                rd_valid,
  input  logic [IDX_W-1:0]    rd_idx,
  input  logic [8:0]          rd_tid,

  output logic                rsp_valid,
  output logic [63:0]         rsp_data,
  output logic [8:0]          rsp_tid,
  output logic                rsp_err
);

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  localparam ctr_t CTR_MAX = '1;
  localparam ctr_t CTR_ONE = ctr_t'(1);

  // Counter state
  ctr_t                cnt_q [N_EVENTS];
  logic [N_EVENTS-1:0] ovf_q;

  // Per-counter clear decode
  logic [N_EVENTS-1:0] clr_hit;

  // Read-side selection of the pre-update counter state
  logic [63:0]         rd_word;
  logic                rd_err;

  // Read pipeline stage 1
  logic                s1_valid;
  logic [63:0]         s1_data;
  logic [8:0]          s1_tid;
  logic                s1_err;

  // Decode which counters a clear request targets; an out-of-range clr_idx
  // matches no counter and so has no effect.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise an unassigned path infers a latch.
    clr_hit = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      clr_hit[i] = clr_valid && (clr_all || (int'(clr_idx) == i));
    end
  end

  // Saturating counters with sticky overflow; clear has priority over events.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the counter array is architectural state with a defined reset
      // value, so it is reset explicitly here rather than inferred as a RAM.
      for (int i = 0; i < N_EVENTS; i++) begin
        cnt_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N_EVENTS; i++) begin
        if (clr_hit[i]) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (ev_enable && ev_in[i]) begin
          if (cnt_q[i] == CTR_MAX) begin
            ovf_q[i] <= 1'b1;
          end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // counter samples the same pre-edge values regardless of order.
            cnt_q[i] <= cnt_q[i] + CTR_ONE;
          end
        end
      end
    end
  end

  // Format the addressed counter as a 64-bit CSR word; out-of-range reads
  // select nothing and return zero with the error flag set.
  always_comb begin
    rd_err  = int'(rd_idx) >= N_EVENTS;
    rd_word = '0;
    for (int i = 0; i < N_EVENTS; i++) begin
      if (int'(rd_idx) == i) begin
        rd_word[CTR_WIDTH-1:0] = cnt_q[i];
        rd_word[63]            = ovf_q[i];
      end
    end
  end

  // Stage 1: capture the read result from the current (pre-update) state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_tid   <= '0;
      s1_err   <= 1'b0;
    end else begin
      s1_valid <= rd_valid;
      if (rd_valid) begin
        s1_data <= rd_word;
        s1_tid  <= rd_tid;
        s1_err  <= rd_err;
      end
    end
  end

  // Stage 2: response strobe; payload holds its last value between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tid   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_data <= s1_data;
        rsp_tid  <= s1_tid;
        rsp_err  <= s1_err;
      end
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_event_ctrs.sv
// Directed testbench for cci_mpf_csr_event_ctrs. Two instances share all
// inputs: the default 48-bit counter bank and a 4-bit bank used to reach
// saturation in a few cycles.

module tb_cci_mpf_csr_event_ctrs;

  localparam int N     = 13;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [N-1:0]     ev_in;
  logic             ev_enable;
  logic             clr_valid;
  logic             clr_all;
  logic [IDX_W-1:0] clr_idx;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [8:0]       rd_tid;

  logic             rsp_valid, rsp_err;
  logic [63:0]      rsp_data;
  logic [8:0]       rsp_tid;
  logic             rsp4_valid, rsp4_err;
  logic [63:0]      rsp4_data;
  logic [8:0]       rsp4_tid;

  int tests_run    = 0;
  int tests_failed = 0;

  cci_mpf_csr_event_ctrs #(.N_EVENTS(N), .CTR_WIDTH(48)) u_dut (
    .clk(clk), .reset_n(reset_n), .ev_in(ev_in), .ev_enable(ev_enable),
    .clr_valid(clr_valid), .clr_all(clr_all), .clr_idx(clr_idx),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_tid(rd_tid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tid(rsp_tid), .rsp_err(rsp_err)
  );

  cci_mpf_csr_event_ctrs #(.N_EVENTS(N), .CTR_WIDTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .ev_in(ev_in), .ev_enable(ev_enable),
    .clr_valid(clr_valid), .clr_all(clr_all), .clr_idx(clr_idx),
    .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_tid(rd_tid),
    .rsp_valid(rsp4_valid), .rsp_data(rsp4_data), .rsp_tid(rsp4_tid), .rsp_err(rsp4_err)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      ev_in = mask;
      cycle();
    end
    ev_in = '0;
  endtask

  task automatic clear(input logic all, input logic [IDX_W-1:0] idx);
    clr_valid = 1'b1;
    clr_all   = all;
    clr_idx   = idx;
    cycle();
    clr_valid = 1'b0;
    clr_all   = 1'b0;
    clr_idx   = '0;
  endtask

  // Issue one read and return what both instances show at T+1 and T+2.
  task automatic read_ctr(input logic [IDX_W-1:0] idx, input logic [8:0] tid,
                          output logic early, output logic v, output logic [63:0] d,
                          output logic [8:0] t, output logic e, output logic [63:0] d4);
    rd_valid = 1'b1;
    rd_idx   = idx;
    rd_tid   = tid;
    cycle();
    rd_valid = 1'b0;
    early    = rsp_valid;
    cycle();
    v  = rsp_valid;
    d  = rsp_data;
    t  = rsp_tid;
    e  = rsp_err;
    d4 = rsp4_data;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ev_in = '0; ev_enable = 1'b1; clr_valid = 1'b0; clr_all = 1'b0;
    clr_idx = '0; rd_valid = 1'b0; rd_idx = '0; rd_tid = '0;
    cycle(); cycle();
    tests_run++; if ({rsp_valid, rsp_err} !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got valid/err=%b, expected 00", {rsp_valid, rsp_err}); end
    tests_run++; if (rsp_data !== 64'h0) begin tests_failed++; $display("FAIL reset_data: got %h, expected 0", rsp_data); end
    tests_run++; if (rsp_tid !== 9'h0) begin tests_failed++; $display("FAIL reset_tid: got %h, expected 0", rsp_tid); end
    reset_n = 1'b1;
    cycle();
  endtask

  task automatic test_basic();
    logic early, v, e; logic [63:0] d, d4; logic [8:0] t;
    pulse(13'b0_0000_0000_0100, 5);
    read_ctr(4'd2, 9'h1A5, early, v, d, t, e, d4);
    tests_run++; if (early !== 1'b0) begin tests_failed++; $display("FAIL basic_latency: rsp_valid at T+1 = %b, expected 0", early); end
    tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: rsp_valid at T+2 = %b, expected 1", v); end
    tests_run++; if (d !== 64'd5) begin tests_failed++; $display("FAIL basic_data: got %h, expected 5", d); end
    tests_run++; if (t !== 9'h1A5) begin tests_failed++; $display("FAIL basic_tid: got %h, expected 1a5", t); end
    tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL basic_err: got %b, expected 0", e); end
    tests_run++; if (d4 !== 64'd5) begin tests_failed++; $display("FAIL basic_data_w4: got %h, expected 5", d4); end
    cycle();
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_strobe: rsp_valid at T+3 = %b, expected 0", rsp_valid); end
  endtask

  task automatic test_saturate();
    logic early, v, e; logic [63:0] d, d4; logic [8:0] t;
    clear(1'b1, '0);
    pulse(13'b0_0000_0000_0001, 17);
    read_ctr(4'd0, 9'h0F0, early, v, d, t, e, d4);
    tests_run++; if (d4 !== 64'h8000_0000_0000_000F) begin tests_failed++; $display("FAIL sat_data_w4: got %h, expected 800000000000000f", d4); end
    tests_run++; if (d !== 64'd17) begin tests_failed++; $display("FAIL sat_data_w48: got %h, expected 11", d); end
    clear(1'b0, 4'd0);
    read_ctr(4'd0, 9'h0F1, early, v, d, t, e, d4);
    tests_run++; if (d4 !== 64'h0) begin tests_failed++; $display("FAIL sat_clear_w4: got %h, expected 0", d4); end
    tests_run++; if (d !== 64'h0) begin tests_failed++; $display("FAIL sat_clear_w48: got %h, expected 0", d); end
  endtask

  task automatic test_collision();
    logic early, v, e; logic [63:0] d, d4; logic [8:0] t;
    pulse(13'b0_0000_0001_1000, 7);
    ev_in = 13'b0_0000_0000_1000;
    clr_valid = 1'b1; clr_all = 1'b0; clr_idx = 4'd3;
    rd_valid = 1'b1; rd_idx = 4'd3; rd_tid = 9'h033;
    cycle();
    ev_in = '0; clr_valid = 1'b0; clr_idx = '0; rd_valid = 1'b0;
    cycle();
    tests_run++; if ({rsp_valid, rsp_data} !== {1'b1, 64'd7}) begin tests_failed++; $display("FAIL coll_preupdate: got valid=%b data=%h, expected 1/7", rsp_valid, rsp_data); end
    read_ctr(4'd3, 9'h034, early, v, d, t, e, d4);
    tests_run++; if (d !== 64'h0) begin tests_failed++; $display("FAIL coll_cleared: got %h, expected 0", d); end
    read_ctr(4'd4, 9'h035, early, v, d, t, e, d4);
    tests_run++; if (d !== 64'd7) begin tests_failed++; $display("FAIL coll_neighbour: got %h, expected 7", d); end
    clear(1'b0, 4'd13);
    read_ctr(4'd4, 9'h036, early, v, d, t, e, d4);
    tests_run++; if (d !== 64'd7) begin tests_failed++; $display("FAIL clr_out_of_range: got %h, expected 7", d); end
  endtask

  task automatic test_back_to_back();
    clear(1'b1, '0);
    pulse(13'b0_0000_0000_0111, 1);
    pulse(13'b0_0000_0000_0110, 1);
    pulse(13'b0_0000_0000_0100, 1);
    rd_valid = 1'b1; rd_idx = 4'd0; rd_tid = 9'h010;
    cycle();
    rd_idx = 4'd1; rd_tid = 9'h011;
    cycle();
    tests_run++; if ({rsp_valid, rsp_data, rsp_tid} !== {1'b1, 64'd1, 9'h010}) begin tests_failed++; $display("FAIL b2b_rsp0: got valid=%b data=%h tid=%h, expected 1/1/010", rsp_valid, rsp_data, rsp_tid); end
    rd_idx = 4'd2; rd_tid = 9'h012;
    cycle();
    tests_run++; if ({rsp_valid, rsp_data, rsp_tid} !== {1'b1, 64'd2, 9'h011}) begin tests_failed++; $display("FAIL b2b_rsp1: got valid=%b data=%h tid=%h, expected 1/2/011", rsp_valid, rsp_data, rsp_tid); end
    rd_valid = 1'b0;
    cycle();
    tests_run++; if ({rsp_valid, rsp_data, rsp_tid} !== {1'b1, 64'd3, 9'h012}) begin tests_failed++; $display("FAIL b2b_rsp2: got valid=%b data=%h tid=%h, expected 1/3/012", rsp_valid, rsp_data, rsp_tid); end
    cycle();
    tests_run++; if ({rsp_valid, rsp_data, rsp_tid} !== {1'b0, 64'd3, 9'h012}) begin tests_failed++; $display("FAIL b2b_hold: got valid=%b data=%h tid=%h, expected 0/3/012", rsp_valid, rsp_data, rsp_tid); end
  endtask

  task automatic test_enable_and_err();
    logic early, v, e; logic [63:0] d, d4; logic [8:0] t;
    ev_enable = 1'b0;
    pulse('1, 10);
    clear(1'b0, 4'd2);
    ev_enable = 1'b1;
    read_ctr(4'd1, 9'h021, early, v, d, t, e, d4);
    tests_run++; if (d !== 64'd2) begin tests_failed++; $display("FAIL enable_hold1: got %h, expected 2", d); end
    read_ctr(4'd0, 9'h020, early, v, d, t, e, d4);
    tests_run++; if (d4 !== 64'd1) begin tests_failed++; $display("FAIL enable_hold0_w4: got %h, expected 1", d4); end
    read_ctr(4'd2, 9'h022, early, v, d, t, e, d4);
    tests_run++; if (d !== 64'h0) begin tests_failed++; $display("FAIL enable_clear: got %h, expected 0", d); end
    read_ctr(4'd13, 9'h0AA, early, v, d, t, e, d4);
    tests_run++; if ({v, e, t} !== {1'b1, 1'b1, 9'h0AA}) begin tests_failed++; $display("FAIL err_idx13: got valid=%b err=%b tid=%h, expected 1/1/0aa", v, e, t); end
    tests_run++; if (d !== 64'h0) begin tests_failed++; $display("FAIL err_idx13_data: got %h, expected 0", d); end
    read_ctr(4'd15, 9'h0AB, early, v, d, t, e, d4);
    tests_run++; if ({e, d} !== {1'b1, 64'h0}) begin tests_failed++; $display("FAIL err_idx15: got err=%b data=%h, expected 1/0", e, d); end
  endtask

  task automatic test_reset_midread();
    logic early, v, e; logic [63:0] d, d4; logic [8:0] t;
    int seen;
    rd_valid = 1'b1; rd_idx = 4'd1; rd_tid = 9'h155;
    cycle();
    rd_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    tests_run++; if ({rsp_valid, rsp_err, rsp_data, rsp_tid} !== '0) begin tests_failed++; $display("FAIL rst_async: got valid=%b err=%b data=%h tid=%h, expected all 0", rsp_valid, rsp_err, rsp_data, rsp_tid); end
    cycle();
    reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (rsp_valid === 1'b1) seen++;
      cycle();
    end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_dropped: got %0d responses, expected 0", seen); end
    read_ctr(4'd1, 9'h0C3, early, v, d, t, e, d4);
    tests_run++; if ({v, d, t} !== {1'b1, 64'h0, 9'h0C3}) begin tests_failed++; $display("FAIL rst_counts: got valid=%b data=%h tid=%h, expected 1/0/0c3", v, d, t); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_collision();
    test_back_to_back();
    test_enable_and_err();
    test_reset_midread();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
